// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
//   fetch_state_t : sequencer state (IDLE, RUN, MISS, PEND)
//   CNT_MAX       : saturation value of a default-width performance counter
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        PEND = 2'd3
    } fetch_state_t;

    localparam int unsigned CNT_WIDTH_DEFAULT = 32;
    localparam logic [CNT_WIDTH_DEFAULT-1:0] CNT_MAX = '1;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   clr_i   : synchronous clear (wins over increment)
//   inc_i   : increment enable; holds once the count reaches all-ones
//   count_o : current count
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer for the pipelined RV32I core. Arbitrates EX redirects, decode
// load-use hazards and instruction-memory wait states (redirect > miss > load-use),
// parking a redirect in PEND while memory is busy.
//   clk, rst                    : clock, synchronous active-high reset
//   trigger                     : run enable; low returns to IDLE
//   imem_ready                  : fetch data valid this cycle
//   hz_load_use                 : decode depends on a load in EX
//   ex_branch_taken, ex_target  : EX redirect request and target
//   pc_en, pc_src, pc_branch    : PC register controls (Mealy)
//   stall_f, stall_d            : fetch / F-D stall
//   flush_d, flush_e            : F-D / D-E bubble
//   stall_cycles                : saturating count of non-IDLE cycles with pc_en=0
//   redirect_count              : saturating count of redirects applied to the PC
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 imem_ready,
    input  logic                 hz_load_use,
    input  logic                 ex_branch_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic [PC_WIDTH-1:0]  pc_branch,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;

    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pc_en         = 1'b0;
        pc_src        = 1'b0;
        pc_branch     = '0;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;

        case (state_q)
            IDLE: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                state_d = RUN;
            end
            RUN, MISS: begin
                if (ex_branch_taken) begin
                    // Wrong-path work in F/D and D/E is squashed either way.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (imem_ready) begin
                        pc_en     = 1'b1;
                        pc_src    = 1'b1;
                        pc_branch = ex_target;
                        state_d   = RUN;
                    end else begin
                        stall_f       = 1'b1;
                        pend_target_d = ex_target;
                        state_d       = PEND;
                    end
                end else if (!imem_ready) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = MISS;
                end else if (hz_load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = RUN;
                end else begin
                    pc_en   = 1'b1;
                    state_d = RUN;
                end
            end
            PEND: begin
                // EX holds a bubble here, so ex_branch_taken cannot be genuine.
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (imem_ready) begin
                    pc_en     = 1'b1;
                    pc_src    = 1'b1;
                    pc_branch = pend_target_q;
                    state_d   = RUN;
                end else begin
                    stall_f = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!trigger) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i  (clk),
        .clr_i  (rst),
        .inc_i  ((state_q != IDLE) && !pc_en),
        .count_o(stall_cycles)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_redirect_cnt (
        .clk_i  (clk),
        .clr_i  (rst),
        .inc_i  (pc_en && pc_src),
        .count_o(redirect_count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Narrow counters make saturation reachable.
module tb_fetch_sequencer;

    localparam int unsigned PW   = 32;
    localparam int unsigned CW   = 6;
    localparam int unsigned CMAX = 63;

    logic          clk = 1'b0;
    logic          rst, trigger, imem_ready, hz_load_use, ex_branch_taken;
    logic [PW-1:0] ex_target;
    logic          pc_en, pc_src, stall_f, stall_d, flush_d, flush_e;
    logic [PW-1:0] pc_branch;
    logic [CW-1:0] stall_cycles, redirect_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PC_WIDTH (PW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .imem_ready     (imem_ready),
        .hz_load_use    (hz_load_use),
        .ex_branch_taken(ex_branch_taken),
        .ex_target      (ex_target),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .pc_branch      (pc_branch),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count)
    );

    // Model: is the core running, is a redirect waiting, and the counters.
    bit          m_active  = 1'b0;
    bit          m_pending = 1'b0;
    logic [31:0] m_target  = '0;
    int          m_stall   = 0;
    int          m_redir   = 0;

    typedef struct packed {
        logic        pc_en;
        logic        pc_src;
        logic [31:0] pc_branch;
        logic        stall_f;
        logic        stall_d;
        logic        flush_d;
        logic        flush_e;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e = '0;
        if (!m_active) begin
            e.flush_d = 1'b1; e.flush_e = 1'b1;
        end else if (m_pending || ex_branch_taken) begin
            e.flush_d = 1'b1; e.flush_e = 1'b1;
            if (imem_ready) begin
                e.pc_en = 1'b1; e.pc_src = 1'b1;
                e.pc_branch = m_pending ? m_target : ex_target;
            end else begin
                e.stall_f = 1'b1;
            end
        end else if (!imem_ready || hz_load_use) begin
            e.stall_f = 1'b1; e.stall_d = 1'b1; e.flush_e = 1'b1;
        end else begin
            e.pc_en = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        e = model_out();
        if (rst) begin
            m_active = 1'b0; m_pending = 1'b0; m_target = '0; m_stall = 0; m_redir = 0;
        end else begin
            if (m_active && !e.pc_en && m_stall != CMAX) m_stall++;
            if (e.pc_en && e.pc_src && m_redir != CMAX) m_redir++;
            if (!trigger) begin
                m_active = 1'b0; m_pending = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
            end else if (m_pending) begin
                if (imem_ready) m_pending = 1'b0;
            end else if (ex_branch_taken && !imem_ready) begin
                m_pending = 1'b1; m_target = ex_target;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model_out();
            chk("m_pc_en",     64'(pc_en),          64'(e.pc_en));
            chk("m_pc_src",    64'(pc_src),         64'(e.pc_src));
            chk("m_pc_branch", 64'(pc_branch),      64'(e.pc_branch));
            chk("m_stall_f",   64'(stall_f),        64'(e.stall_f));
            chk("m_stall_d",   64'(stall_d),        64'(e.stall_d));
            chk("m_flush_d",   64'(flush_d),        64'(e.flush_d));
            chk("m_flush_e",   64'(flush_e),        64'(e.flush_e));
            chk("m_stall_cnt", 64'(stall_cycles),   64'(m_stall));
            chk("m_redir_cnt", 64'(redirect_count), 64'(m_redir));
        end
    end

    // One cycle: drive inputs after the edge, return at the negedge for literal checks.
    task automatic cyc(input bit r, input bit t, input bit rdy, input bit hz, input bit br,
                       input logic [31:0] tg);
        @(posedge clk);
        #1;
        rst = r; trigger = t; imem_ready = rdy; hz_load_use = hz;
        ex_branch_taken = br; ex_target = tg;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; trigger = 1'b1; imem_ready = 1'b1;
        hz_load_use = 1'b0; ex_branch_taken = 1'b0; ex_target = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_pc_en", 64'(pc_en), 64'd0);
        chk("rst_flush_d", 64'(flush_d), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cycles), 64'd0);
        cyc(1, 1, 1, 0, 0, 0);

        // First cycle out of reset is IDLE, then free-running fetch.
        cyc(0, 1, 1, 0, 0, 0);
        chk("idle_pc_en", 64'(pc_en), 64'd0);
        chk("idle_flush_e", 64'(flush_e), 64'd1);
        repeat (3) begin
            cyc(0, 1, 1, 0, 0, 0);
            chk("run_pc_en", 64'(pc_en), 64'd1);
            chk("run_pc_src", 64'(pc_src), 64'd0);
        end

        // Load-use bubble.
        cyc(0, 1, 1, 1, 0, 0);
        chk("lu_stall_d", 64'(stall_d), 64'd1);
        chk("lu_pc_en", 64'(pc_en), 64'd0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lu_stall_cnt", 64'(stall_cycles), 64'd1);

        // Redirect with memory ready.
        cyc(0, 1, 1, 0, 1, 32'hBFC0_0040);
        chk("br_pc_src", 64'(pc_src), 64'd1);
        chk("br_pc_branch", 64'(pc_branch), 64'hBFC0_0040);
        chk("br_flush_d", 64'(flush_d), 64'd1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("br_redir_cnt", 64'(redirect_count), 64'd1);

        // Redirect parked while memory is busy; a second request in PEND is ignored.
        cyc(0, 1, 0, 0, 1, 32'hBFC0_0100);
        chk("pend_in_stall_f", 64'(stall_f), 64'd1);
        chk("pend_in_pc_en", 64'(pc_en), 64'd0);
        cyc(0, 1, 0, 0, 1, 32'hDEAD_0000);
        chk("pend_ign_pc_src", 64'(pc_src), 64'd0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("pend_out_pc_en", 64'(pc_en), 64'd1);
        chk("pend_out_branch", 64'(pc_branch), 64'hBFC0_0100);
        cyc(0, 1, 1, 0, 0, 0);
        chk("pend_stall_cnt", 64'(stall_cycles), 64'd4);
        chk("pend_redir_cnt", 64'(redirect_count), 64'd2);

        // Miss beats load-use; load-use re-evaluated after the miss.
        cyc(0, 1, 0, 1, 0, 0);
        chk("miss_flush_d", 64'(flush_d), 64'd0);
        cyc(0, 1, 1, 1, 0, 0);
        chk("miss_lu_stall_d", 64'(stall_d), 64'd1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("miss_stall_cnt", 64'(stall_cycles), 64'd6);

        // Redirect beats load-use; redirect out of MISS.
        cyc(0, 1, 1, 1, 1, 32'h0000_1000);
        chk("brlu_branch", 64'(pc_branch), 64'h1000);
        chk("brlu_stall_d", 64'(stall_d), 64'd0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 32'h0000_2000);
        chk("miss_br_branch", 64'(pc_branch), 64'h2000);

        // Trigger dropped in PEND: redirect discarded, counters held.
        cyc(0, 1, 0, 0, 1, 32'h0000_3000);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            cyc(0, 0, 1, 0, 0, 0);
            chk("trig_pc_en", 64'(pc_en), 64'd0);
        end
        chk("trig_stall_cnt", 64'(stall_cycles), 64'd10);
        chk("trig_redir_cnt", 64'(redirect_count), 64'd4);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("trig_no_redir", 64'(pc_src), 64'd0);
        chk("trig_pc_en_run", 64'(pc_en), 64'd1);

        // Reset in PEND clears everything.
        cyc(0, 1, 0, 0, 1, 32'h0000_4000);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("rstp_stall_cnt", 64'(stall_cycles), 64'd0);
        chk("rstp_redir_cnt", 64'(redirect_count), 64'd0);
        chk("rstp_pc_en", 64'(pc_en), 64'd0);
        cyc(0, 1, 1, 0, 0, 0);

        // Counter saturation.
        repeat (62) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("sat_stall_62", 64'(stall_cycles), 64'd62);
        repeat (3) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("sat_stall_max", 64'(stall_cycles), 64'(CMAX));
        for (int i = 0; i < 70; i++) cyc(0, 1, 1, 0, 1, 32'(i * 4));
        cyc(0, 1, 1, 0, 0, 0);
        chk("sat_redir_max", 64'(redirect_count), 64'(CMAX));

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the PC register for the pipelined RV32I core; the PC register itself is a separate module.
- Drives the PC's `en`, `pc_src` and `pc_branch` inputs, and the fetch/decode stall and decode/execute flush controls.
- Arbitrates three events: EX-stage branch/jump redirects, decode load-use hazards, and instruction-memory wait states.
- Holds a redirect that arrives while instruction memory is busy, and keeps saturating stall and redirect performance counters.

Parameters:
- `PC_WIDTH`, 32, width of PC and redirect target.
- `CNT_WIDTH`, 32, width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `trigger`  in  1  core run enable; low holds the sequencer idle.
- `imem_ready`  in  1  instruction memory has valid data for the current fetch PC this cycle.
- `hz_load_use`  in  1  decode instruction depends on a load currently in EX.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `ex_target`  in  PC_WIDTH  redirect target, valid with `ex_branch_taken`.
- `pc_en`  out  1  PC advance enable.
- `pc_src`  out  1  PC mux select: 1 selects `pc_branch`.
- `pc_branch`  out  PC_WIDTH  redirect target to the PC.
- `stall_f`  out  1  hold the fetch stage.
- `stall_d`  out  1  hold the F/D pipeline register.
- `flush_d`  out  1  bubble the F/D register.
- `flush_e`  out  1  bubble the D/E register.
- `stall_cycles`  out  CNT_WIDTH  count of cycles in RUN/MISS/PEND with `pc_en`=0.
- `redirect_count`  out  CNT_WIDTH  count of redirects applied to the PC.

Behaviour:
- States: IDLE, RUN, MISS, PEND. State register and `pend_target` register update on posedge `clk`.
- `rst`=1, or `trigger`=0, forces next state IDLE. Only `rst` clears the counters and `pend_target`; `trigger`=0 leaves them unchanged.

Outputs (Mealy), per state:
- IDLE:
  - `pc_en`=0, `pc_src`=0, `pc_branch`=0, `stall_f`=0, `stall_d`=0, `flush_d`=1, `flush_e`=1.
  - Next state RUN when `rst`=0 and `trigger`=1.
  - Reset values of all outputs are the IDLE values, with both counters at 0.
- RUN and MISS share the same output rules; priority is redirect > miss > load-use.
  - Redirect with `ex_branch_taken`=1 and `imem_ready`=1:
    - `pc_en`=1, `pc_src`=1, `pc_branch`=`ex_target`, `flush_d`=1, `flush_e`=1.
    - `redirect_count` += 1. Next state RUN.
  - Redirect with `ex_branch_taken`=1 and `imem_ready`=0:
    - `pc_en`=0, `stall_f`=1, `flush_d`=1, `flush_e`=1.
    - `pend_target` <= `ex_target`. Next state PEND.
  - Miss with `imem_ready`=0:
    - `pc_en`=0, `stall_f`=1, `stall_d`=1, `flush_e`=1. Next state MISS.
  - Load-use with `hz_load_use`=1:
    - `pc_en`=0, `stall_f`=1, `stall_d`=1, `flush_e`=1. Next state RUN.
  - Otherwise:
    - `pc_en`=1, `pc_src`=0, all stalls and flushes 0. Next state RUN.
- PEND:
  - `ex_branch_taken` is ignored, because EX holds a bubble.
  - `imem_ready`=0: `pc_en`=0, `stall_f`=1, `flush_d`=1, `flush_e`=1; stay in PEND.
  - `imem_ready`=1: `pc_en`=1, `pc_src`=1, `pc_branch`=`pend_target`, `flush_d`=1, `flush_e`=1; `redirect_count` += 1; next state RUN.
- `pc_branch` outputs 0 whenever `pc_src`=0.

Counters:
- Both counters saturate at all-ones and never wrap.
- `stall_cycles` increments in any cycle where the state is not IDLE and `pc_en`=0.

Simultaneous events and boundaries:
- A redirect with load-use in the same cycle is handled as a redirect. The load-use instruction is on the wrong path and gets flushed.
- A miss with load-use in the same cycle is handled as a miss. Load-use is re-evaluated once `imem_ready` returns.
- Reset or `trigger`=0 while in PEND discards the redirect; the PC restarts at its reset vector.
- Latency: a redirect reaches the PC one edge after `ex_branch_taken` when memory is ready. Otherwise it reaches the PC one edge after the first `imem_ready`=1 in PEND.

Decomposition:
- Package `fetch_seq_pkg`:
  - `fetch_state_t` enum: IDLE, RUN, MISS, PEND.
  - `CNT_MAX` constant.
- Sub-module `sat_counter`: parameterised width, synchronous clear, increment enable, saturates at max. Instantiated twice.

Test Plan:
- Reset with `trigger`=1 and `imem_ready`=1, then release `rst` → IDLE outputs for 1 cycle, then `pc_en`=1 and `pc_src`=0 every cycle; counters stay 0.
- `hz_load_use`=1 for 1 cycle in RUN → `pc_en`=0, `stall_f`=`stall_d`=`flush_e`=1 for 1 cycle; `stall_cycles`=1.
- `ex_branch_taken`=1, `ex_target`=`0xBFC00040`, `imem_ready`=1 → `pc_src`=1, `pc_branch`=`0xBFC00040`, `flush_d`=`flush_e`=1; `redirect_count`=1.
- `ex_branch_taken`=1, `ex_target`=`0xBFC00100`, with `imem_ready`=0 for 3 cycles:
  - Expect PEND and `pc_en`=0 for 3 cycles, then `pc_branch`=`0xBFC00100` with `pc_en`=1.
  - Expect `stall_cycles`=3 and `redirect_count`=1.
  - Asserting `ex_branch_taken` again during PEND has no effect.
- Drive `trigger` low mid-PEND → next cycle IDLE; the pending redirect is never applied; counters are held.
- Preload counters to all-ones minus 1 and stall 3 cycles → `stall_cycles` saturates at all-ones and stays there.
